// File: rtl/mod_mul_serial.sv
// Serial modular multiplier: R = (a*b) mod prime_q.
// MSB-first interleaved double-and-add, one bit of b per clock.
// Optional build macro MOD_MUL_INPUT_REDUCE_EN adds a one-cycle REDUCE
// state that folds operands in [q, 2q) back into [0, q) before RUN.
//
// state  | meaning
// IDLE   | waiting for go
// REDUCE | (macro only) subtract q once from captured a and b if >= q
// RUN    | double-and-add for bit idx of b, idx counts N-1 down to 0
// DONE   | R valid for one cycle; go here starts the next operation
module mod_mul_serial #(
    parameter int MODULU_LENGTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     go,
    input  logic [MODULU_LENGTH-1:0] prime_q,
    input  logic [MODULU_LENGTH-1:0] a,
    input  logic [MODULU_LENGTH-1:0] b,
    output logic                     busy,
    output logic                     valid,
    output logic [MODULU_LENGTH-1:0] R
);

    localparam int N  = MODULU_LENGTH;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

`ifdef MOD_MUL_INPUT_REDUCE_EN
    typedef enum logic [1:0] {IDLE, REDUCE, RUN, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif

    state_t        state;
    logic [N-1:0]  acc;
    logic [N-1:0]  a_r;
    logic [N-1:0]  b_r;
    logic [N-1:0]  q_r;
    logic [IW-1:0] idx;

    logic [N:0]    q_ext;
    logic [N:0]    dbl;
    logic [N:0]    dbl_red;
    logic [N:0]    sum;
    logic [N-1:0]  acc_next;

    // One double-and-add step; N+1-bit intermediates keep the carry that
    // 2*acc or acc+a can produce before the conditional subtraction.
    always_comb begin
        q_ext    = {1'b0, q_r};
        dbl      = {acc, 1'b0};
        dbl_red  = (dbl >= q_ext) ? (dbl - q_ext) : dbl;
        sum      = b_r[idx] ? (dbl_red + {1'b0, a_r}) : dbl_red;
        // Result is < q, so the low N bits of the difference are exact.
        acc_next = (sum >= q_ext) ? (sum[N-1:0] - q_r) : sum[N-1:0];
    end

    // Sequencer with registered busy/valid/R; DONE shares the start path
    // with IDLE so a held go yields back-to-back operations.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            valid <= 1'b0;
            R     <= '0;
            acc   <= '0;
            idx   <= '0;
            a_r   <= '0;
            b_r   <= '0;
            q_r   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    valid <= 1'b0;
                    if (go) begin
                        a_r  <= a;
                        b_r  <= b;
                        q_r  <= prime_q;
                        acc  <= '0;
                        idx  <= IW'(N - 1);
                        busy <= 1'b1;
`ifdef MOD_MUL_INPUT_REDUCE_EN
                        state <= REDUCE;
`else
                        state <= RUN;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
`ifdef MOD_MUL_INPUT_REDUCE_EN
                REDUCE: begin
                    if (a_r >= q_r) a_r <= a_r - q_r;
                    if (b_r >= q_r) b_r <= b_r - q_r;
                    state <= RUN;
                end
`endif
                RUN: begin
                    acc <= acc_next;
                    if (idx == '0) begin
                        R     <= acc_next;
                        valid <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod_mul_serial.sv
// Directed bench for mod_mul_serial at N=32, q=0xFFFFFFFB.
// Latency is counted in rising edges after the edge that samples go.
module tb_mod_mul_serial;

    localparam int N = 32;
`ifdef MOD_MUL_INPUT_REDUCE_EN
    localparam int LAT = N + 1;
`else
    localparam int LAT = N;
`endif
    localparam logic [31:0] Q = 32'hFFFF_FFFB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        go = 1'b0;
    logic [31:0] prime_q = Q;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        valid;
    logic [31:0] R;

    int checks = 0;
    int errors = 0;

    mod_mul_serial #(.MODULU_LENGTH(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .go      (go),
        .prime_q (prime_q),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .valid   (valid),
        .R       (R)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait for valid, bounded; returns number of edges waited.
    task automatic wait_valid(output int lat, output bit seen);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 4 * N) begin
            @(posedge clk); #1;
            lat++;
            if (valid) seen = 1'b1;
        end
    endtask

    task automatic do_op(input logic [31:0] xa, input logic [31:0] xb,
                         input logic [31:0] exp, input string tag);
        int lat;
        bit seen;
        a = xa; b = xb; go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        chk({tag, "_busy_run"}, 64'(busy), 64'd1);
        wait_valid(lat, seen);
        chk({tag, "_seen"}, 64'(seen), 64'd1);
        chk({tag, "_lat"}, 64'(lat), 64'(LAT));
        chk({tag, "_R"}, 64'(R), 64'(exp));
        chk({tag, "_busy_done"}, 64'(busy), 64'd0);
        @(posedge clk); #1;
        chk({tag, "_pulse"}, 64'(valid), 64'd0);
        chk({tag, "_R_hold"}, 64'(R), 64'(exp));
    endtask

    initial begin
        int lat;
        bit seen;
        int vcount;
        int last_edge;
        int edge_no;

        // Reset state
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_R", 64'(R), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic and boundary products
        do_op(32'd2, 32'd3, 32'd6, "mul_2x3");
        do_op(32'hFFFF_FFFA, 32'hFFFF_FFFA, 32'd1, "mul_qm1_sq");
        do_op(32'h8000_0000, 32'h8000_0000, 32'h4000_0005, "mul_2p31_sq");
        do_op(32'h1234_5678, 32'd1, 32'h1234_5678, "mul_b1");

        // go re-pulsed mid-operation with new operands is ignored; R holds
        a = 32'd2; b = 32'd3; go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        for (int i = 1; i < 5; i++) begin
            @(posedge clk); #1;
        end
        a = 32'd5; b = 32'd7; go = 1'b1;
        chk("ignore_R_hold", 64'(R), 64'h1234_5678);
        @(posedge clk); #1;
        go = 1'b0;
        lat = 5;
        seen = 1'b0;
        while (!seen && lat < 4 * N) begin
            @(posedge clk); #1;
            lat++;
            if (valid) seen = 1'b1;
        end
        chk("ignore_seen", 64'(seen), 64'd1);
        chk("ignore_lat", 64'(lat), 64'(LAT));
        chk("ignore_R", 64'(R), 64'd6);
        @(posedge clk); #1;

        do_op(32'd0, 32'hFFFF_FFFA, 32'd0, "mul_a0");

        // Reset mid-operation aborts with no valid pulse
        do_op(32'd2, 32'd3, 32'd6, "pre_rst");
        a = 32'h8000_0000; b = 32'h8000_0000; go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        for (int i = 1; i < 10; i++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_valid", 64'(valid), 64'd0);
        chk("abort_R", 64'(R), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < N + 8; i++) begin
            @(posedge clk); #1;
            if (valid) seen = 1'b1;
        end
        chk("abort_no_valid", 64'(seen), 64'd0);
        do_op(32'd2, 32'd3, 32'd6, "post_rst");

        // go held high: back-to-back operations
        a = 32'd3; b = 32'd4; go = 1'b1;
        @(posedge clk); #1;
        edge_no   = 0;
        vcount    = 0;
        last_edge = 0;
        while (vcount < 3 && edge_no < 10 * N) begin
            @(posedge clk); #1;
            edge_no++;
            if (valid) begin
                if (vcount == 0)
                    chk("b2b_first", 64'(edge_no), 64'(LAT));
                else
                    chk("b2b_period", 64'(edge_no - last_edge), 64'(LAT + 1));
                chk("b2b_R", 64'(R), 64'd12);
                last_edge = edge_no;
                vcount++;
            end
        end
        chk("b2b_count", 64'(vcount), 64'd3);
        go = 1'b0;
        wait_valid(lat, seen);
        @(posedge clk); #1;
        chk("b2b_idle_busy", 64'(busy), 64'd0);

`ifdef MOD_MUL_INPUT_REDUCE_EN
        do_op(32'hFFFF_FFFE, 32'd2, 32'd6, "reduce_a");
        do_op(32'd5, 32'hFFFF_FFFC, 32'd5, "reduce_b");
`else
        do_op(32'hFFFF_FFFA, 32'd2, 32'hFFFF_FFF9, "mul_qm1_x2");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
